// File: rtl/rng_pkg.sv
// Shared definitions for the game random-number arbiter: LFSR geometry,
// feedback taps, arbiter FSM state encoding and the Galois step helper.
package rng_pkg;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        COOL  = 2'd2
    } rng_state_t;

    // One Galois right-shift step. An all-zero state cannot advance on its
    // own, so it is replaced by the supplied fallback seed.
    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] q,
        input logic [LFSR_W-1:0] fallback
    );
        logic [LFSR_W-1:0] n;
        if (q == {LFSR_W{1'b0}}) begin
            n = fallback;
        end else begin
            n = {1'b0, q[LFSR_W-1:1]} ^ (q[0] ? LFSR_TAPS : {LFSR_W{1'b0}});
        end
        return n;
    endfunction

endpackage

// File: rtl/lfsr16_core.sv
// 16-bit Galois LFSR that advances every cycle. A load pulse replaces the
// step with a new seed; a zero load value selects the built-in seed so the
// register can never be parked in the all-zero lock-up state.
module lfsr16_core
    import rng_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Load,
    input  logic [LFSR_W-1:0] LoadVal,
    output logic [LFSR_W-1:0] Q
);

    logic [LFSR_W-1:0] q_r;
    logic [LFSR_W-1:0] q_s;
    logic [LFSR_W-1:0] load_val_s;

    // Choose between a reseed and the normal Galois step.
    always_comb begin
        load_val_s = SEED;
        q_s        = q_r;
        if (LoadVal != {LFSR_W{1'b0}}) begin
            load_val_s = LoadVal;
        end else begin
            load_val_s = SEED;
        end
        if (Load) begin
            q_s = load_val_s;
        end else begin
            q_s = lfsr_next(q_r, SEED);
        end
    end

    // State register; reset restores the default seed.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            q_r <= SEED;
        end else begin
            q_r <= q_s;
        end
    end

    assign Q = q_r;

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one LFSR among several requesters. Each grant
// returns the low LFSR bits sampled in the granting cycle, then a cooldown
// keeps the LFSR advancing STRIDE times before the next grant.
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int              NUM_REQ = 4,
    parameter int              DATA_W  = 8,
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
    parameter int              STRIDE  = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NUM_REQ-1:0] Req,
    input  logic               SeedLoad,
    input  logic [LFSR_W-1:0]  SeedIn,
    output logic [NUM_REQ-1:0] Grant,
    output logic [DATA_W-1:0]  Data,
    output logic               Valid,
    output logic               Busy
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int COOL_W = $clog2(STRIDE + 1);

    localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]     NUM_REQ_W  = (PTR_W + 1)'(NUM_REQ);
    localparam logic [COOL_W-1:0]  COOL_ONE   = COOL_W'(1'b1);
    localparam logic [COOL_W-1:0]  COOL_START = COOL_W'(STRIDE - 1);
    localparam logic [NUM_REQ-1:0] GRANT_ONE  = NUM_REQ'(1'b1);

    // Round-robin pick: rotate the request vector so the pointer position
    // sits at bit 0, take the lowest set bit, then rotate the index back.
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [PTR_W-1:0]   ptr
    );
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        logic [PTR_W-1:0]     off;
        logic [PTR_W:0]       sum;
        dbl = {req, req} >> ptr;
        rot = dbl[NUM_REQ-1:0];
        off = {PTR_W{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = PTR_W'(i);
            end else begin
                off = off;
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NUM_REQ_W) begin
            sum = sum - NUM_REQ_W;
        end else begin
            sum = sum;
        end
        return sum[PTR_W-1:0];
    endfunction

    logic [LFSR_W-1:0]  lfsr_q_s;
    logic               unused_lfsr_s;

    rng_state_t         state_r;
    rng_state_t         state_s;
    logic [COOL_W-1:0]  cool_cnt_r;
    logic [COOL_W-1:0]  cool_cnt_s;
    logic [PTR_W-1:0]   rr_ptr_r;
    logic [PTR_W-1:0]   rr_ptr_s;
    logic [PTR_W-1:0]   winner_s;
    logic [NUM_REQ-1:0] grant_r;
    logic [NUM_REQ-1:0] grant_s;
    logic [DATA_W-1:0]  data_r;
    logic [DATA_W-1:0]  data_s;
    logic               valid_r;
    logic               valid_s;
    logic               busy_r;
    logic               busy_s;

    lfsr16_core #(
        .SEED    (SEED)
    ) u_lfsr (
        .Clk     (Clk),
        .Reset   (Reset),
        .Load    (SeedLoad),
        .LoadVal (SeedIn),
        .Q       (lfsr_q_s)
    );

    // Bits above the draw width only feed back into the LFSR itself.
    assign unused_lfsr_s = ^lfsr_q_s;

    // Next-state and next-output logic for the IDLE/GRANT/COOL sequence.
    always_comb begin
        state_s    = state_r;
        cool_cnt_s = cool_cnt_r;
        rr_ptr_s   = rr_ptr_r;
        grant_s    = {NUM_REQ{1'b0}};
        data_s     = data_r;
        valid_s    = 1'b0;
        winner_s   = rr_pick(Req, rr_ptr_r);

        if (SeedLoad) begin
            // Reseeding aborts any grant or cooldown in flight.
            state_s    = IDLE;
            cool_cnt_s = {COOL_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (|Req) begin
                        grant_s = GRANT_ONE << winner_s;
                        data_s  = lfsr_q_s[DATA_W-1:0];
                        valid_s = 1'b1;
                        state_s = GRANT;
                        if (winner_s == PTR_LAST) begin
                            rr_ptr_s = {PTR_W{1'b0}};
                        end else begin
                            rr_ptr_s = winner_s + PTR_ONE;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                GRANT: begin
                    if (STRIDE == 1) begin
                        state_s = IDLE;
                    end else begin
                        state_s    = COOL;
                        cool_cnt_s = COOL_START;
                    end
                end
                COOL: begin
                    if (cool_cnt_r <= COOL_ONE) begin
                        cool_cnt_s = {COOL_W{1'b0}};
                        state_s    = IDLE;
                    end else begin
                        cool_cnt_s = cool_cnt_r - COOL_ONE;
                        state_s    = COOL;
                    end
                end
                default: begin
                    state_s    = IDLE;
                    cool_cnt_s = {COOL_W{1'b0}};
                end
            endcase
        end

        busy_s = (state_s != IDLE);
    end

    // FSM and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r    <= IDLE;
            cool_cnt_r <= {COOL_W{1'b0}};
            rr_ptr_r   <= {PTR_W{1'b0}};
            grant_r    <= {NUM_REQ{1'b0}};
            data_r     <= {DATA_W{1'b0}};
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cool_cnt_r <= cool_cnt_s;
            rr_ptr_r   <= rr_ptr_s;
            grant_r    <= grant_s;
            data_r     <= data_s;
            valid_r    <= valid_s;
            busy_r     <= busy_s;
        end
    end

    assign Grant = grant_r;
    assign Data  = data_r;
    assign Valid = valid_r;
    assign Busy  = busy_r;

endmodule
